ibuffer: RTL

Instruction buffer between the instruction fetch unit and the decoder. It accepts whole fetch groups of `INSTR_PER_FETCH` instructions with the group PC, and stores each instruction with its own PC in a circular FIFO. It presents up to `DECODE_WIDTH` oldest instructions per cycle to decode. It absorbs fetch/decode rate mismatch and is cleared by the backend flush.

---
 rtl/global_config_pkg.sv | 21 ++
 rtl/ibuffer.sv | 91 +++++++++
 2 files changed

// File: rtl/global_config_pkg.sv
// Shared front-end configuration: fetch/decode widths, buffer depth and the
// instruction-buffer entry layout.
package global_config_pkg;

  localparam int unsigned IBUF_ILEN = 32;
  localparam int unsigned IBUF_PLEN = 32;

  typedef struct packed {
    logic [IBUF_ILEN-1:0] instr;
    logic [IBUF_PLEN-1:0] pc;
  } ibuffer_entry_t;

  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned DECODE_WIDTH;
    int unsigned IBUF_DEPTH;
  } cfg_t;

  localparam cfg_t cfg = '{INSTR_PER_FETCH: 4, DECODE_WIDTH: 4, IBUF_DEPTH: 16};

endpackage

// File: rtl/ibuffer.sv
// Instruction buffer: circular FIFO of {instr, pc} between fetch and decode.
// Accepts whole fetch groups and presents up to DECODE_WIDTH oldest entries.
module ibuffer
  import global_config_pkg::*;
#(
  parameter int unsigned INSTR_PER_FETCH = cfg.INSTR_PER_FETCH,
  parameter int unsigned DECODE_WIDTH    = cfg.DECODE_WIDTH,
  parameter int unsigned DEPTH           = cfg.IBUF_DEPTH,
  parameter int unsigned ILEN            = IBUF_ILEN,
  parameter int unsigned PLEN            = IBUF_PLEN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic                              ifu_ibuffer_rsp_valid_i,
  output logic                              ibuffer_ifu_rsp_ready_o,
  input  logic [PLEN-1:0]                   ifu_ibuffer_rsp_pc_i,
  input  logic [INSTR_PER_FETCH*ILEN-1:0]   ifu_ibuffer_rsp_data_i,
  output logic [DECODE_WIDTH-1:0]           ibuffer_dec_valid_o,
  output logic [DECODE_WIDTH*ILEN-1:0]      ibuffer_dec_instr_o,
  output logic [DECODE_WIDTH*PLEN-1:0]      ibuffer_dec_pc_o,
  input  logic                              dec_ibuffer_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [PLEN-1:0] pc_q    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_out;
  logic          enq, deq;

  // Ready only looks at registered occupancy; a same-cycle dequeue is not credited.
  assign ibuffer_ifu_rsp_ready_o = (count_q <= CW'(DEPTH - INSTR_PER_FETCH));
  assign n_out = (count_q > CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : count_q;

  assign enq = ifu_ibuffer_rsp_valid_i & ibuffer_ifu_rsp_ready_o & ~flush_i;
  assign deq = dec_ibuffer_ready_i & ~flush_i;

  always_comb begin
    ibuffer_dec_valid_o = '0;
    ibuffer_dec_instr_o = '0;
    ibuffer_dec_pc_o    = '0;
    for (int j = 0; j < int'(DECODE_WIDTH); j++) begin
      ibuffer_dec_valid_o[j]            = (CW'(j) < n_out);
      ibuffer_dec_instr_o[j*ILEN +: ILEN] = instr_q[rd_ptr_q + PW'(j)];
      ibuffer_dec_pc_o[j*PLEN +: PLEN]    = pc_q[rd_ptr_q + PW'(j)];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(INSTR_PER_FETCH);
      count_d  = count_d + CW'(INSTR_PER_FETCH);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(n_out);
      count_d  = count_d - n_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale entries are hidden by the valid bits.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
        instr_q[wr_ptr_q + PW'(i)] <= ifu_ibuffer_rsp_data_i[i*ILEN +: ILEN];
        pc_q[wr_ptr_q + PW'(i)]    <= ifu_ibuffer_rsp_pc_i + PLEN'(4 * i);
      end
    end
  end

endmodule
